// File: rtl/core_launcher.sv
// rtl/core_launcher.sv - host-side initiator: preload register file, Start/Ack with timeout, stream dump
module core_launcher #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    input  logic [DATA_W-1:0] InitVal,
    output logic              Busy,
    output logic              Done,
    output logic              TimedOut,
    output logic              RfWe,
    output logic [ADDR_W-1:0] RfAddr,
    output logic [DATA_W-1:0] RfWrData,
    input  logic [DATA_W-1:0] RfRdData,
    output logic              Start,
    input  logic              Ack,
    output logic              DumpValid,
    output logic [ADDR_W-1:0] DumpAddr,
    output logic [DATA_W-1:0] DumpData,
    input  logic              DumpReady
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_START, S_WAIT, S_DUMP, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [TO_W-1:0]   LAST_CNT = TO_W'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [TO_W-1:0]   cnt;
    logic [DATA_W-1:0] seed;
    logic              timed_out;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            seed      <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Go) begin
                        seed      <= InitVal;
                        timed_out <= 1'b0;
                        idx       <= '0;
                        state     <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_START;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Ack wins over an expiry landing in the same cycle
                    if (Ack) begin
                        idx   <= '0;
                        state <= S_DUMP;
                    end else if (cnt == LAST_CNT) begin
                        timed_out <= 1'b1;
                        idx       <= '0;
                        state     <= S_DUMP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DUMP: begin
                    if (DumpReady) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Decoded from the state register only, so async reset clears them at once
    assign Busy      = (state != S_IDLE);
    assign RfWe      = (state == S_INIT);
    assign Start     = (state == S_START);
    assign DumpValid = (state == S_DUMP);
    assign Done      = (state == S_DONE);
    assign TimedOut  = timed_out;
    assign RfAddr    = (RfWe || DumpValid) ? idx : '0;
    assign RfWrData  = RfWe ? seed : '0;
    assign DumpAddr  = DumpValid ? idx : '0;
    assign DumpData  = DumpValid ? RfRdData : '0;

endmodule

// File: tb/tb_core_launcher.sv
// tb/tb_core_launcher.sv - randomized bench for core_launcher against a timeline model
module tb_core_launcher;

    localparam int N  = 16;
    localparam int TO = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Go = 1'b0;
    logic       Ack = 1'b0;
    logic       DumpReady = 1'b1;
    logic [7:0] InitVal = 8'h00;
    logic       Busy, Done, TimedOut, RfWe, Start, DumpValid;
    logic [3:0] RfAddr, DumpAddr;
    logic [7:0] RfWrData, RfRdData, DumpData;

    int checks = 0;
    int fails  = 0;

    core_launcher #(.NUM_REGS(N), .ADDR_W(4), .DATA_W(8), .TIMEOUT(TO), .TO_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .InitVal(InitVal),
        .Busy(Busy), .Done(Done), .TimedOut(TimedOut),
        .RfWe(RfWe), .RfAddr(RfAddr), .RfWrData(RfWrData), .RfRdData(RfRdData),
        .Start(Start), .Ack(Ack),
        .DumpValid(DumpValid), .DumpAddr(DumpAddr), .DumpData(DumpData), .DumpReady(DumpReady)
    );

    always #5 Clk = ~Clk;

    // Register file stand-in; scramble fills it with junk so dumps prove the preload happened
    logic       scramble = 1'b0;
    logic [7:0] rf [N];
    assign RfRdData = rf[RfAddr];
    always @(posedge Clk) begin
        if (scramble) begin
            for (int i = 0; i < N; i++) rf[i] <= 8'($urandom);
        end else if (RfWe) begin
            rf[RfAddr] <= RfWrData;
        end
    end

    // Timeline model: a run is described by when INIT began, when DUMP began and how many words moved
    int         cyc = 0;
    int         go_t = 0;
    int         dump_t = -1;
    int         xfers = 0;
    bit         run_on = 1'b0;
    bit         timed = 1'b0;
    logic [7:0] seed_m = 8'h00;

    function automatic int mphase(input int c);
        if (!run_on)            return 0;
        if (c < go_t + N)       return 1;
        if (c == go_t + N)      return 2;
        if (dump_t < 0)         return 3;
        if (xfers < N)          return 4;
        return 5;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_on <= 1'b0;
            timed  <= 1'b0;
            seed_m <= 8'h00;
            xfers  <= 0;
            dump_t <= -1;
        end else begin
            cyc <= cyc + 1;
            case (mphase(cyc))
                0: if (Go) begin
                    run_on <= 1'b1;
                    go_t   <= cyc + 1;
                    dump_t <= -1;
                    xfers  <= 0;
                    timed  <= 1'b0;
                    seed_m <= InitVal;
                end
                3: if (Ack) begin
                    dump_t <= cyc + 1;
                end else if (cyc - (go_t + N + 1) == TO - 1) begin
                    timed  <= 1'b1;
                    dump_t <= cyc + 1;
                end
                4: if (DumpReady) xfers <= xfers + 1;
                5: run_on <= 1'b0;
                default: ;
            endcase
        end
    end

    always @(negedge Clk) begin : compare
        int p;
        logic [29:0] a, e;
        p = mphase(cyc);
        a = {Busy, RfWe, Start, DumpValid, Done, TimedOut, RfAddr,
             (p == 1 || !Reset) ? RfWrData : 8'h00,
             (p == 4 || !Reset) ? DumpAddr : 4'h0,
             (p == 4 || !Reset) ? DumpData : 8'h00};
        e = {p != 0, p == 1, p == 2, p == 4, p == 5, timed,
             (p == 1) ? 4'(cyc - go_t) : (p == 4) ? 4'(xfers) : 4'h0,
             (p == 1) ? seed_m : 8'h00,
             (p == 4) ? 4'(xfers) : 4'h0,
             (p == 4) ? seed_m : 8'h00};
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL cycle_outputs @%0d phase %0d: actual %h required %h", cyc, p, a, e);
        end
    end

    int   n_we = 0, n_start = 0, n_xfer = 0, n_done = 0;
    int   first_we = 0, start_c = 0, first_dv = 0, done_c = 0;
    logic prev_we = 1'b0, prev_dv = 1'b0;
    always @(negedge Clk) begin
        if (RfWe) n_we <= n_we + 1;
        if (RfWe && !prev_we) first_we <= cyc;
        if (Start) begin
            n_start <= n_start + 1;
            start_c <= cyc;
        end
        if (DumpValid && !prev_dv) first_dv <= cyc;
        if (DumpValid && DumpReady) n_xfer <= n_xfer + 1;
        if (Done) begin
            n_done <= n_done + 1;
            done_c <= cyc;
        end
        prev_we <= RfWe;
        prev_dv <= DumpValid;
    end

    int bp_mode = 0;
    int bp_k = 0;
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            case (bp_mode)
                0:       DumpReady = 1'b1;
                1:       DumpReady = (bp_k % 4 == 0) || (bp_k % 4 == 3);
                default: DumpReady = 1'($urandom_range(0, 1));
            endcase
            bp_k++;
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // d = WAIT cycle (1-based) carrying Ack; 0 = Ack during START; -1 = never
    task automatic run(input logic [7:0] seed, input int d, input int bp, input bit noise);
        int g, b_we, b_st, b_x, b_d, exp_wait, kmax;
        bit found, eff;
        eff      = (d >= 1 && d <= TO);
        exp_wait = eff ? d : TO;
        bp_mode  = bp;
        scramble = 1'b1;
        @(posedge Clk); #1 scramble = 1'b0;
        b_we = n_we; b_st = n_start; b_x = n_xfer; b_d = n_done;
        Go = 1'b1; InitVal = seed; g = cyc;
        @(posedge Clk); #1 Go = 1'b0; InitVal = 8'($urandom);
        @(negedge Clk);
        check("busy_after_go", Busy, 1);
        check("timedout_cleared_on_go", TimedOut, 0);
        if (noise) begin
            @(posedge Clk); #1 Go = 1'b1; Ack = 1'b1; InitVal = 8'($urandom);
            @(posedge Clk); #1 Go = 1'b0; Ack = 1'b0;
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge Clk);
            found = Start;
        end
        check("start_seen", found, 1);
        Ack  = (d == 0);
        kmax = ((d > 2) ? d : 2) + 1;
        for (int k = 1; k <= kmax; k++) begin
            @(posedge Clk); #1;
            Go  = noise && (k == 2);
            Ack = (k == d);
        end
        Go = 1'b0; Ack = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge Clk);
            found = Done;
        end
        check("done_seen", found, 1);
        @(posedge Clk); #1;
        check("timedout_after_done", TimedOut, eff ? 0 : 1);
        check("write_count", n_we - b_we, N);
        check("start_pulses", n_start - b_st, 1);
        check("init_begins_after_go", first_we - g, 1);
        check("start_after_init", start_c - first_we, N);
        check("wait_length", first_dv - start_c - 1, exp_wait);
        check("transfer_count", n_xfer - b_x, N);
        check("done_pulses", n_done - b_d, 1);
        if (bp == 0) check("dump_cycles", done_c - first_dv, N);
    endtask

    task automatic mid_reset(input bit in_dump);
        int bd;
        bit found;
        bp_mode = 0;
        Go = 1'b1; InitVal = 8'($urandom);
        @(posedge Clk); #1 Go = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge Clk);
            found = Start;
        end
        check("mr_start_seen", found, 1);
        if (in_dump) begin
            @(posedge Clk); #1 Ack = 1'b1;
            @(posedge Clk); #1 Ack = 1'b0;
        end else begin
            @(posedge Clk);
            @(posedge Clk); #1;
        end
        check("mr_pre_busy", Busy, 1);
        check("mr_pre_dumpvalid", DumpValid, in_dump);
        bd = n_done;
        Reset = 1'b0;
        #1;
        check("mr_async_busy", Busy, 0);
        check("mr_async_dumpvalid", DumpValid, 0);
        check("mr_async_start", Start, 0);
        check("mr_async_rfwe", RfWe, 0);
        @(posedge Clk);
        @(posedge Clk); #1 Reset = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        check("mr_no_done", n_done - bd, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_timedout", TimedOut, 0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        run(8'h01, 5, 0, 1'b0);
        run(8'($urandom), -1, 0, 1'b0);
        run(8'($urandom), 3, 1, 1'b0);
        run(8'($urandom), 4, 0, 1'b1);
        run(8'($urandom), 0, 0, 1'b1);
        run(8'($urandom), TO, 0, 1'b0);
        run(8'($urandom), TO + 1, 0, 1'b0);
        mid_reset(1'b0);
        mid_reset(1'b1);
        run(8'hA5, 5, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            run(8'($urandom), int'($urandom_range(0, 12)) - 1,
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
